// File: rtl/fifo_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_arbiter_pkg
// Description : State encoding and sizing helper for the FIFO read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_read_arbiter_pkg;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_grant  = 2'd1;
    localparam logic [1:0] c_st_locked = 2'd2;

    // Unlimited bursts still need a one-bit counter so the register is legal.
    function automatic int burst_cnt_width(input int max_burst);
        return (max_burst == 0) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_read_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_arbiter_rr_pick
// Description : Finds the first set bit at or after a start index, cyclic.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_arbiter_rr_pick #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] i_vec,
    input  logic [IDX_W-1:0] i_start,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    localparam logic [IDX_W:0] c_width = (IDX_W + 1)'(WIDTH);

    logic [IDX_W:0] w_pos;

    // Scan from the far end so the candidate closest to i_start wins last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            w_pos = {1'b0, i_start} + (IDX_W + 1)'(k);
            if (w_pos >= c_width) begin
                w_pos = w_pos - c_width;
            end
            if (i_vec[w_pos[IDX_W-1:0]]) begin
                o_found = 1'b1;
                o_idx   = w_pos[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_arbiter
// Description : Round-robin / lock read arbiter from N FWFT source FIFOs
//               onto the single out_fifo read port.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_arbiter
    import fifo_read_arbiter_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                           BUS_CLK,
    input  logic                           BUS_RST,
    input  logic [CHANNELS-1:0]            ENABLE_MASK,
    input  logic [CHANNELS-1:0]            LOCK_REQ,
    input  logic [CHANNELS-1:0]            IN_EMPTY,
    input  logic [CHANNELS*DATA_WIDTH-1:0] IN_DATA,
    output logic [CHANNELS-1:0]            IN_READ,
    input  logic                           OUT_READ,
    output logic                           OUT_EMPTY,
    output logic [DATA_WIDTH-1:0]          OUT_DATA,
    output logic [CHANNELS-1:0]            GRANT,
    output logic                           LOCKED,
    output logic                           READ_ERROR
);

    localparam int                  c_idx_w     = $clog2(CHANNELS);
    localparam int                  c_cnt_w     = burst_cnt_width(MAX_BURST);
    localparam logic [c_idx_w-1:0]  c_last_ch   = c_idx_w'(CHANNELS - 1);
    localparam logic [c_cnt_w-1:0]  c_max_burst = c_cnt_w'(MAX_BURST);

    logic [1:0]            r_state, w_state_nxt;
    logic [c_idx_w-1:0]    r_gidx, w_gidx_nxt;
    logic [c_idx_w-1:0]    r_last, w_last_nxt;
    logic [c_cnt_w-1:0]    r_cnt, w_cnt_nxt;
    logic                  r_read_error;

    logic [DATA_WIDTH-1:0] w_in_words [CHANNELS];
    logic [CHANNELS-1:0]   w_elig, w_lock_cand;
    logic [c_idx_w-1:0]    w_rr_base, w_rr_start, w_elig_idx, w_lock_idx;
    logic                  w_elig_found, w_lock_found;
    logic                  w_active, w_out_empty, w_pop, w_burst_done, w_rotate, w_rearb;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
        assign w_in_words[gi] = IN_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_active    = (r_state != c_st_idle);
    assign w_out_empty = ~w_active | IN_EMPTY[r_gidx];
    assign w_pop       = OUT_READ & ~w_out_empty;
    assign w_elig      = ENABLE_MASK & ~IN_EMPTY;
    assign w_lock_cand = ENABLE_MASK & LOCK_REQ;

    // While granted, rotation starts after the owner, which becomes last-served.
    assign w_rr_base  = (r_state == c_st_grant) ? r_gidx : r_last;
    assign w_rr_start = (w_rr_base == c_last_ch) ? '0 : w_rr_base + 1'b1;

    assign w_burst_done = (MAX_BURST != 0) && w_pop && ((r_cnt + 1'b1) == c_max_burst);
    assign w_rotate     = IN_EMPTY[r_gidx] | ~ENABLE_MASK[r_gidx] | w_burst_done;

    fifo_read_arbiter_rr_pick #(.WIDTH(CHANNELS), .IDX_W(c_idx_w)) u_rr_elig (
        .i_vec   (w_elig),
        .i_start (w_rr_start),
        .o_found (w_elig_found),
        .o_idx   (w_elig_idx)
    );

    fifo_read_arbiter_rr_pick #(.WIDTH(CHANNELS), .IDX_W(c_idx_w)) u_rr_lock (
        .i_vec   (w_lock_cand),
        .i_start ('0),
        .o_found (w_lock_found),
        .o_idx   (w_lock_idx)
    );

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_state      <= c_st_idle;
            r_gidx       <= '0;
            r_last       <= c_last_ch;
            r_cnt        <= '0;
            r_read_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gidx  <= w_gidx_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            if (OUT_READ && w_out_empty) begin
                r_read_error <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gidx_nxt  = r_gidx;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_rearb     = 1'b0;
        case (r_state)
            c_st_idle: w_rearb = 1'b1;
            c_st_grant: begin
                if (w_rotate) begin
                    w_rearb    = 1'b1;
                    w_last_nxt = r_gidx;
                end else if (w_pop && (MAX_BURST != 0)) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_st_locked: begin
                if (!(LOCK_REQ[r_gidx] && ENABLE_MASK[r_gidx])) begin
                    w_rearb = 1'b1;
                end
            end
            default: w_rearb = 1'b1;
        endcase
        // Lock requests always beat the round-robin pick.
        if (w_rearb) begin
            w_cnt_nxt = '0;
            if (w_lock_found) begin
                w_state_nxt = c_st_locked;
                w_gidx_nxt  = w_lock_idx;
            end else if (w_elig_found) begin
                w_state_nxt = c_st_grant;
                w_gidx_nxt  = w_elig_idx;
            end else begin
                w_state_nxt = c_st_idle;
                w_gidx_nxt  = '0;
            end
        end
    end

    always_comb begin
        GRANT      = '0;
        IN_READ    = '0;
        OUT_EMPTY  = w_out_empty;
        OUT_DATA   = w_active ? w_in_words[r_gidx] : '0;
        LOCKED     = (r_state == c_st_locked);
        READ_ERROR = r_read_error;
        if (w_active) begin
            GRANT[r_gidx] = 1'b1;
        end
        if (w_pop) begin
            IN_READ[r_gidx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_read_arbiter
// Description : Randomised self-checking bench with a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    en, lock, in_empty, in_read, grant;
    logic [N*DW-1:0] in_data;
    logic            out_read, out_empty, locked, read_error;
    logic [DW-1:0]   out_data;

    logic [N-1:0]    en_b, lock_b, in_empty_b, in_read_b, grant_b;
    logic [N*DW-1:0] in_data_b;
    logic            out_read_b, out_empty_b, locked_b, read_error_b;
    logic [DW-1:0]   out_data_b;

    fifo_read_arbiter #(.CHANNELS(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .BUS_CLK(clk), .BUS_RST(rst), .ENABLE_MASK(en), .LOCK_REQ(lock),
        .IN_EMPTY(in_empty), .IN_DATA(in_data), .IN_READ(in_read),
        .OUT_READ(out_read), .OUT_EMPTY(out_empty), .OUT_DATA(out_data),
        .GRANT(grant), .LOCKED(locked), .READ_ERROR(read_error)
    );

    fifo_read_arbiter #(.CHANNELS(N), .DATA_WIDTH(DW), .MAX_BURST(0)) dut_ub (
        .BUS_CLK(clk), .BUS_RST(rst), .ENABLE_MASK(en_b), .LOCK_REQ(lock_b),
        .IN_EMPTY(in_empty_b), .IN_DATA(in_data_b), .IN_READ(in_read_b),
        .OUT_READ(out_read_b), .OUT_EMPTY(out_empty_b), .OUT_DATA(out_data_b),
        .GRANT(grant_b), .LOCKED(locked_b), .READ_ERROR(read_error_b)
    );

    logic [DW-1:0] src_q [N][$];
    logic [DW-1:0] src_b [N][$];
    int            pop_log[$];
    int            n_checks = 0;
    int            n_errors = 0;

    // Reference: owner (-1 = none), lock flag, burst count, last-served.
    int m_owner, m_cnt, m_last;
    bit m_locked, m_rderr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void drive_srcs();
        for (int i = 0; i < N; i++) begin
            in_empty[i]         = (src_q[i].size() == 0);
            in_data[i*DW +: DW] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
            in_empty_b[i]         = (src_b[i].size() == 0);
            in_data_b[i*DW +: DW] = (src_b[i].size() != 0) ? src_b[i][0] : '0;
        end
    endfunction

    function automatic void model_reset();
        m_owner = -1; m_locked = 0; m_cnt = 0; m_last = N - 1; m_rderr = 0;
    endfunction

    function automatic void arbitrate(input int after);
        m_cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (en[i] && lock[i]) begin
                m_owner = i; m_locked = 1; return;
            end
        end
        m_locked = 0;
        for (int k = 1; k <= N; k++) begin
            if (en[(after + k) % N] && src_q[(after + k) % N].size() > 0) begin
                m_owner = (after + k) % N; return;
            end
        end
        m_owner = -1;
    endfunction

    function automatic void fill(input int ch, input int n);
        for (int k = 0; k < n; k++) src_q[ch].push_back({8'(ch), 8'(k), 16'($urandom)});
    endfunction

    task automatic step();
        logic [N-1:0]  e_grant, e_inread, obs_rd, one;
        logic [DW-1:0] e_data;
        bit            e_empty, e_pop;
        int            o;
        one = 1;
        @(negedge clk);
        drive_srcs();
        #1;
        obs_rd = in_read;
        if (rst) begin
            model_reset();
            e_grant = '0; e_inread = '0; e_empty = 1; e_data = '0;
        end else begin
            o        = m_owner;
            e_empty  = (o < 0) || (src_q[o].size() == 0);
            e_data   = (o < 0 || src_q[o].size() == 0) ? '0 : src_q[o][0];
            e_pop    = out_read && !e_empty;
            e_grant  = (o < 0) ? '0 : (one << o);
            e_inread = e_pop ? (one << o) : '0;
        end
        chk("grant", grant, e_grant);
        chk("in_read", in_read, e_inread);
        chk("out_empty", out_empty, e_empty);
        chk("out_data", out_data, e_data);
        chk("locked", locked, m_locked && m_owner >= 0);
        chk("read_error", read_error, m_rderr);
        chk("grant_onehot0", $onehot0(grant), 1);
        if (!rst) begin
            if (out_read && e_empty) m_rderr = 1;
            if (o < 0) arbitrate(m_last);
            else if (m_locked) begin
                if (!(lock[o] && en[o])) arbitrate(m_last);
            end else if (src_q[o].size() == 0 || !en[o] || (e_pop && MB != 0 && m_cnt + 1 == MB)) begin
                m_last = o;
                arbitrate(o);
            end else if (e_pop) m_cnt++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (obs_rd[i]) begin
                if (src_q[i].size() > 0) void'(src_q[i].pop_front());
                pop_log.push_back(i);
            end
        end
        drive_srcs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        lock = '0; out_read = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_order[20];
        int cnt, ch;
        exp_order = '{1,1,1,1,2,2,2,2,1,1,1,1,2,2,2,2,1,1,2,2};
        en = '0; lock = '0; out_read = 1'b0;
        en_b = '0; lock_b = '0; out_read_b = 1'b0;
        model_reset();
        drive_srcs();
        step(); step();
        rst = 1'b0;

        // Burst rotation between two loaded channels
        en = '1; out_read = 1'b1; fill(1, 10); fill(2, 10); pop_log.delete();
        repeat (30) step();
        chk("burst_pop_count", pop_log.size(), 20);
        for (int i = 0; i < 20 && i < pop_log.size(); i++)
            chk($sformatf("burst_order_%0d", i), pop_log[i], exp_order[i]);

        // Lock request waits for the rotate point, then holds while empty
        do_reset();
        en = '1; out_read = 1'b1; fill(0, 3);
        step(); step();
        lock[3] = 1'b1;
        repeat (3) step();
        #1;
        chk("lock_locked", locked, 1);
        chk("lock_grant", grant, 4'b1000);
        chk("lock_out_empty", out_empty, 1);
        out_read = 1'b0; step();
        fill(3, 5); out_read = 1'b1; pop_log.delete();
        repeat (8) step();
        cnt = 0;
        foreach (pop_log[i]) if (pop_log[i] == 3) cnt++;
        chk("lock_ch3_pops", cnt, 5);
        chk("lock_held_empty", grant, 4'b1000);
        fill(1, 4); lock[3] = 1'b0;
        step();
        #1;
        chk("release_grant", grant, 4'b0010);
        chk("release_locked", locked, 0);

        // Masked channels never served
        do_reset();
        en = 4'b0101;
        for (int i = 0; i < N; i++) fill(i, 6);
        pop_log.delete();
        repeat (40) begin
            out_read = ($urandom_range(0, 3) != 0);
            step();
        end
        cnt = 0;
        foreach (pop_log[i]) if (pop_log[i] == 1 || pop_log[i] == 3) cnt++;
        chk("mask_ch13_pops", cnt, 0);

        // Sticky read error
        do_reset();
        en = '1; out_read = 1'b1; step();
        out_read = 1'b0;
        repeat (100) step();
        chk("rderr_sticky", read_error, 1);
        rst = 1'b1;
        #1;
        chk("rderr_cleared", read_error, 0);
        step();
        rst = 1'b0;

        // Asynchronous reset in the middle of a burst
        do_reset();
        en = '1; out_read = 1'b1; fill(1, 8);
        repeat (3) step();
        @(negedge clk);
        #3;
        chk("pre_rst_in_read", in_read, 4'b0010);
        rst = 1'b1;
        #1;
        chk("async_rst_grant", grant, 0);
        chk("async_rst_in_read", in_read, 0);
        fill(0, 4);
        step();
        rst = 1'b0;
        step();
        #1;
        chk("restart_at_ch0", grant, 4'b0001);

        // Randomised traffic
        do_reset();
        en = '1;
        repeat (400) begin
            if ($urandom_range(0, 7) == 0) en = N'($urandom) | N'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                ch = $urandom_range(0, N - 1);
                lock[ch] = ~lock[ch];
            end
            out_read = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                ch = $urandom_range(0, N - 1);
                if (src_q[ch].size() < 8) src_q[ch].push_back($urandom);
            end
            step();
        end

        // Unlimited burst instance drains ch1 before serving ch2
        for (int k = 0; k < 50; k++) src_b[1].push_back(32'h1000 + k);
        for (int k = 0; k < 5; k++)  src_b[2].push_back(32'h2000 + k);
        en_b = '1; out_read_b = 1'b1; pop_log.delete();
        repeat (80) begin
            logic [N-1:0] obs;
            @(negedge clk);
            drive_srcs();
            #1;
            obs = in_read_b;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (obs[i]) begin
                    if (src_b[i].size() > 0) void'(src_b[i].pop_front());
                    pop_log.push_back(i);
                end
            end
        end
        chk("ub_pop_count", pop_log.size(), 55);
        cnt = 0;
        for (int i = 0; i < 50 && i < pop_log.size(); i++) if (pop_log[i] == 1) cnt++;
        chk("ub_ch1_first50", cnt, 50);
        chk("ub_then_ch2", (pop_log.size() > 50) ? pop_log[50] : -1, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
